// File: rtl/tile_pkg.sv
// Shared types and width helpers for the tile index generator.
// Latency: n/a (package only). Backpressure: n/a.
// Holds the FSM state enum, the bound clamp and the index/config width rules.
package tile_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEF_MAX_COLS  = 32;
  localparam int DEF_MAX_ROWS  = 32;
  localparam int DEF_MAX_TILES = 16;

  // Index width: enough bits for 0..max_val-1, never narrower than one bit.
  function automatic int idx_width(input int max_val);
    return (max_val > 1) ? $clog2(max_val) : 1;
  endfunction

  // Config width: enough bits to express the count max_val itself.
  function automatic int cfg_width(input int max_val);
    return $clog2(max_val + 1);
  endfunction

  // A zero or out-of-range count falls back to the maximum.
  function automatic int clamp_bound(input int val, input int max_val);
    return ((val == 0) || (val > max_val)) ? max_val : val;
  endfunction

endpackage

// File: rtl/tile_index_gen_wrap_cnt.sv
// Single-level wrapping counter with enable, clear and runtime bound.
// Latency: count updates 1 cycle after en; wrap is combinational. Backpressure: holds while en=0.
// Optional TILE_IDX_SERPENTINE_EN adds a down-count direction and restart-from-top.
module wrap_cnt #(
  parameter int W  = 5,
  parameter int BW = 6
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          en,
`ifdef TILE_IDX_SERPENTINE_EN
  input  logic          dir_dn,
  input  logic          dir_dn_next,
`endif
  input  logic [BW-1:0] bound,
  output logic [W-1:0]  cnt,
  output logic          wrap
);

  localparam int XW = (BW > W) ? BW : W;

  logic [W-1:0]  cnt_q, cnt_d;
  logic [XW-1:0] top_val;
  logic          at_top;

  assign top_val = XW'(bound) - XW'(1);
  assign at_top  = (XW'(cnt_q) == top_val);

`ifdef TILE_IDX_SERPENTINE_EN
  assign wrap = dir_dn ? (cnt_q == '0) : at_top;

  // On wrap, restart at whichever end the following pass begins from.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      if (wrap) begin
        cnt_d = dir_dn_next ? top_val[W-1:0] : '0;
      end else if (dir_dn) begin
        cnt_d = cnt_q - W'(1);
      end else begin
        cnt_d = cnt_q + W'(1);
      end
    end
  end
`else
  assign wrap = at_top;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = wrap ? '0 : cnt_q + W'(1);
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/tile_index_gen.sv
// Three-level (col, row, tile) index sequencer with latched bounds; macro TILE_IDX_SERPENTINE_EN.
// Latency: first index valid 1 cycle after start; done pulses 1 cycle after the final handshake.
// Backpressure: valid/ready; indices and flags hold while ready is low.
module tile_index_gen
  import tile_pkg::*;
#(
  parameter  int MAX_COLS  = DEF_MAX_COLS,
  parameter  int MAX_ROWS  = DEF_MAX_ROWS,
  parameter  int MAX_TILES = DEF_MAX_TILES,
  localparam int CW  = idx_width(MAX_COLS),
  localparam int RW  = idx_width(MAX_ROWS),
  localparam int TW  = idx_width(MAX_TILES),
  localparam int CCW = cfg_width(MAX_COLS),
  localparam int CRW = cfg_width(MAX_ROWS),
  localparam int CTW = cfg_width(MAX_TILES)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic           abort,
  input  logic [CCW-1:0] cfg_cols,
  input  logic [CRW-1:0] cfg_rows,
  input  logic [CTW-1:0] cfg_tiles,
  input  logic           ready,
  output logic           valid,
  output logic [CW-1:0]  col_idx,
  output logic [RW-1:0]  row_idx,
  output logic [TW-1:0]  tile_idx,
  output logic           last_col,
  output logic           last_row,
  output logic           last,
  output logic           busy,
  output logic           done
);

  state_t         state_q, state_d;
  logic [CCW-1:0] cols_q, cols_d;
  logic [CRW-1:0] rows_q, rows_d;
  logic [CTW-1:0] tiles_q, tiles_d;

  logic hs, start_acc, clr;
  logic row_en, tile_en;
  logic col_wrap, row_wrap, tile_wrap;

  assign valid = (state_q == RUN);
  assign busy  = (state_q != IDLE);
  assign done  = (state_q == DONE);
  assign hs    = valid & ready;

  always_comb begin
    state_d   = state_q;
    cols_d    = cols_q;
    rows_d    = rows_q;
    tiles_d   = tiles_q;
    start_acc = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && !abort) begin
          start_acc = 1'b1;
          state_d   = RUN;
          cols_d    = CCW'(clamp_bound(int'(cfg_cols),  MAX_COLS));
          rows_d    = CRW'(clamp_bound(int'(cfg_rows),  MAX_ROWS));
          tiles_d   = CTW'(clamp_bound(int'(cfg_tiles), MAX_TILES));
        end
      end
      RUN: begin
        // Abort outranks a coincident final handshake, so no done follows.
        if (abort) begin
          state_d = IDLE;
        end else if (hs && last) begin
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cols_q  <= '0;
      rows_q  <= '0;
      tiles_q <= '0;
    end else begin
      state_q <= state_d;
      cols_q  <= cols_d;
      rows_q  <= rows_d;
      tiles_q <= tiles_d;
    end
  end

  assign clr     = abort | start_acc;
  assign row_en  = hs & col_wrap;
  assign tile_en = row_en & row_wrap;

  // The final handshake wraps every level, which returns the indices to zero.
  assign last_col = valid & col_wrap;
  assign last_row = last_col & row_wrap;
  assign last     = last_row & tile_wrap;

`ifdef TILE_IDX_SERPENTINE_EN
  logic col_dn, col_dn_next;

  // Odd rows descend; a row wrap always lands on even row 0.
  assign col_dn      = row_idx[0];
  assign col_dn_next = row_wrap ? 1'b0 : ~row_idx[0];
`endif

  wrap_cnt #(.W(CW), .BW(CCW)) u_col (
    .clk         (clk),
    .rst         (rst),
    .clr         (clr),
    .en          (hs),
`ifdef TILE_IDX_SERPENTINE_EN
    .dir_dn      (col_dn),
    .dir_dn_next (col_dn_next),
`endif
    .bound       (cols_q),
    .cnt         (col_idx),
    .wrap        (col_wrap)
  );

  wrap_cnt #(.W(RW), .BW(CRW)) u_row (
    .clk         (clk),
    .rst         (rst),
    .clr         (clr),
    .en          (row_en),
`ifdef TILE_IDX_SERPENTINE_EN
    .dir_dn      (1'b0),
    .dir_dn_next (1'b0),
`endif
    .bound       (rows_q),
    .cnt         (row_idx),
    .wrap        (row_wrap)
  );

  wrap_cnt #(.W(TW), .BW(CTW)) u_tile (
    .clk         (clk),
    .rst         (rst),
    .clr         (clr),
    .en          (tile_en),
`ifdef TILE_IDX_SERPENTINE_EN
    .dir_dn      (1'b0),
    .dir_dn_next (1'b0),
`endif
    .bound       (tiles_q),
    .cnt         (tile_idx),
    .wrap        (tile_wrap)
  );

endmodule

// File: tb/tb_tile_index_gen.sv
// Bench for tile_index_gen: randomized ready/stimulus against a nested-loop sequence model.
module tb_tile_index_gen;

  localparam int MC = 32, MR = 32, MT = 16;
  localparam int CCW = 6, CRW = 6, CTW = 5;
  localparam int CW = 5, RW = 5, TW = 4;

  logic           clk = 1'b0;
  logic           rst, start, abort, ready;
  logic [CCW-1:0] cfg_cols;
  logic [CRW-1:0] cfg_rows;
  logic [CTW-1:0] cfg_tiles;
  logic           valid, last_col, last_row, last, busy, done;
  logic [CW-1:0]  col_idx;
  logic [RW-1:0]  row_idx;
  logic [TW-1:0]  tile_idx;

  // valid, col, row, tile, last_col, last_row, last, done, busy
  logic [19:0] obs;
  assign obs = {valid, col_idx, row_idx, tile_idx, last_col, last_row, last, done, busy};

  int errors = 0;
  int checks = 0;

  int exp_c[$], exp_r[$], exp_t[$];
  bit exp_lc[$], exp_lr[$], exp_l[$];

  always #5 clk = ~clk;

  tile_index_gen #(.MAX_COLS(MC), .MAX_ROWS(MR), .MAX_TILES(MT)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .abort     (abort),
    .cfg_cols  (cfg_cols),
    .cfg_rows  (cfg_rows),
    .cfg_tiles (cfg_tiles),
    .ready     (ready),
    .valid     (valid),
    .col_idx   (col_idx),
    .row_idx   (row_idx),
    .tile_idx  (tile_idx),
    .last_col  (last_col),
    .last_row  (last_row),
    .last      (last),
    .busy      (busy),
    .done      (done)
  );

  function automatic int clampv(input int v, input int m);
    return ((v == 0) || (v > m)) ? m : v;
  endfunction

  // Expected handshake sequence: tile outer, row middle, col inner.
  task automatic build_model(input int c, input int r, input int t);
    int n;
    exp_c.delete(); exp_r.delete(); exp_t.delete();
    exp_lc.delete(); exp_lr.delete(); exp_l.delete();
    for (int ti = 0; ti < t; ti++)
      for (int ri = 0; ri < r; ri++)
        for (int k = 0; k < c; k++) begin
          int ci;
          ci = k;
`ifdef TILE_IDX_SERPENTINE_EN
          if (ri % 2 == 1) ci = c - 1 - k;
`endif
          exp_c.push_back(ci);
          exp_r.push_back(ri);
          exp_t.push_back(ti);
        end
    n = exp_c.size();
    for (int i = 0; i < n; i++) begin
      exp_lc.push_back(((i + 1) % c) == 0);
      exp_lr.push_back(((i + 1) % (c * r)) == 0);
      exp_l.push_back(i == n - 1);
    end
  endtask

  function automatic logic [19:0] exp_vec(input int i);
    return {1'b1, CW'(exp_c[i]), RW'(exp_r[i]), TW'(exp_t[i]),
            exp_lc[i], exp_lr[i], exp_l[i], 1'b0, 1'b1};
  endfunction

  // mode 0: ready always 1; 1: ready 1,0,0 repeating; 2: random ready.
  task automatic run_seq(input int c, input int r, input int t, input int mode, input bit poke);
    int n, hs, cyc;
    logic [19:0] expv;
    build_model(clampv(c, MC), clampv(r, MR), clampv(t, MT));
    n = exp_c.size();
    cfg_cols = CCW'(c); cfg_rows = CRW'(r); cfg_tiles = CTW'(t);
    start = 1'b1; ready = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    hs = 0; cyc = 0;
    while (hs < n && cyc < n * 4 + 50) begin
      expv = exp_vec(hs);
      checks++;
      if (obs !== expv) begin
        errors++;
        $display("FAIL seq %0dx%0dx%0d step %0d: got %h want %h", c, r, t, hs, obs, expv);
      end
      case (mode)
        0:       ready = 1'b1;
        1:       ready = (cyc % 3 == 0);
        default: ready = 1'($urandom_range(0, 1));
      endcase
      if (poke) begin
        start     = 1'($urandom_range(0, 1));
        cfg_cols  = CCW'($urandom);
        cfg_rows  = CRW'($urandom);
        cfg_tiles = CTW'($urandom);
      end
      @(posedge clk); #1;
      if (ready) hs++;
      cyc++;
    end
    start = 1'b0;
    ready = 1'($urandom_range(0, 1));
    checks++;
    if (hs < n) begin
      errors++;
      $display("FAIL seq %0dx%0dx%0d timeout: got %0d handshakes want %0d", c, r, t, hs, n);
    end
    checks++;
    if (obs !== 20'h00003) begin
      errors++;
      $display("FAIL done_pulse %0dx%0dx%0d: got %h want %h", c, r, t, obs, 20'h00003);
    end
    @(posedge clk); #1;
    checks++;
    if (obs !== 20'h00000) begin
      errors++;
      $display("FAIL idle_after_done %0dx%0dx%0d: got %h want %h", c, r, t, obs, 20'h00000);
    end
  endtask

  // Start a sequence and stop with the DUT presenting entry k (ready=1 throughout).
  task automatic start_and_advance(input int c, input int r, input int t, input int k);
    logic [19:0] expv;
    build_model(c, r, t);
    cfg_cols = CCW'(c); cfg_rows = CRW'(r); cfg_tiles = CTW'(t);
    start = 1'b1; ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i <= k; i++) begin
      expv = exp_vec(i);
      checks++;
      if (obs !== expv) begin
        errors++;
        $display("FAIL advance step %0d: got %h want %h", i, obs, expv);
      end
      if (i < k) begin
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic expect_quiet(input string name, input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk); #1;
      checks++;
      if (obs !== 20'h00000) begin
        errors++;
        $display("FAIL %s cycle %0d: got %h want %h", name, i, obs, 20'h00000);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; abort = 1'b0; ready = 1'b1;
    cfg_cols = 6'd3; cfg_rows = 6'd2; cfg_tiles = 5'd2;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (obs !== 20'h00000) begin
      errors++;
      $display("FAIL reset_state: got %h want %h", obs, 20'h00000);
    end
    rst = 1'b0; start = 1'b0;
    expect_quiet("idle_no_start", 2);
  endtask

  task automatic test_basic();
    run_seq(3, 2, 2, 0, 1'b0);
  endtask

  task automatic test_backpressure();
    run_seq(4, 1, 1, 1, 1'b0);
    run_seq(3, 3, 2, 2, 1'b0);
  endtask

  task automatic test_clamp();
    run_seq(0, 40, 1, 0, 1'b0);
  endtask

  task automatic test_unit_bounds();
    run_seq(1, 1, 1, 2, 1'b0);
    run_seq(1, 3, 2, 2, 1'b0);
    run_seq(5, 1, 1, 2, 1'b0);
  endtask

  task automatic test_abort();
    start_and_advance(8, 8, 1, 9);
    abort = 1'b1; start = 1'b1; ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (obs !== 20'h00000) begin
      errors++;
      $display("FAIL abort_next: got %h want %h", obs, 20'h00000);
    end
    // abort and start together in IDLE: start must be ignored
    @(posedge clk); #1;
    checks++;
    if (obs !== 20'h00000) begin
      errors++;
      $display("FAIL abort_start_idle: got %h want %h", obs, 20'h00000);
    end
    abort = 1'b0; start = 1'b0;
    expect_quiet("after_abort", 4);
    run_seq(2, 2, 1, 0, 1'b0);
    // abort coinciding with the final handshake
    start_and_advance(2, 1, 1, 1);
    abort = 1'b1; ready = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    checks++;
    if (obs !== 20'h00000) begin
      errors++;
      $display("FAIL abort_on_last: got %h want %h", obs, 20'h00000);
    end
    expect_quiet("after_abort_last", 3);
  endtask

  task automatic test_reset_mid();
    start_and_advance(8, 8, 2, 29);
    rst = 1'b1; ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (obs !== 20'h00000) begin
      errors++;
      $display("FAIL reset_mid: got %h want %h", obs, 20'h00000);
    end
    rst = 1'b0;
    expect_quiet("after_reset_mid", 4);
    run_seq(3, 2, 1, 2, 1'b0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 8; i++) begin
      run_seq(int'($urandom_range(1, 6)), int'($urandom_range(1, 4)),
              int'($urandom_range(1, 3)), 2, 1'b1);
    end
  endtask

  task automatic test_serpentine();
    run_seq(3, 2, 1, 0, 1'b0);
    run_seq(4, 3, 2, 2, 1'b0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_clamp();
    test_unit_bounds();
    test_abort();
    test_reset_mid();
    test_random();
    test_serpentine();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/tile_index_gen.md
Name: tile_index_gen

Overview:
- Parametrised successor to the two-level pixel/slice counter. Produces a three-level (col, row, tile) index sequence that drives operand fetch and result write-back in the systolic matrix-multiply datapath.
- Runtime-configurable bounds are latched on a start pulse.
- Has a valid/ready handshake so downstream back-pressure stalls the sequence, plus per-level "last" flags, a done pulse and an abort.

Parameters:
- MAX_COLS, 32: maximum columns (innermost, fastest-changing).
- MAX_ROWS, 32: maximum rows (middle level).
- MAX_TILES, 16: maximum tiles (outermost level).
- Derived widths: CW = max(clog2(MAX_COLS),1), RW = max(clog2(MAX_ROWS),1), TW = max(clog2(MAX_TILES),1).
- Derived config widths: CCW = clog2(MAX_COLS+1), CRW = clog2(MAX_ROWS+1), CTW = clog2(MAX_TILES+1).

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request to begin a sequence.
- abort  in  1  terminate the current sequence.
- cfg_cols  in  CCW  column count for the next sequence.
- cfg_rows  in  CRW  row count for the next sequence.
- cfg_tiles  in  CTW  tile count for the next sequence.
- ready  in  1  downstream accepts the current index.
- valid  out  1  current index is valid.
- col_idx  out  CW  current column index.
- row_idx  out  RW  current row index.
- tile_idx  out  TW  current tile index.
- last_col  out  1  col_idx == cols-1.
- last_row  out  1  last_col and row_idx == rows-1.
- last  out  1  last_row and tile_idx == tiles-1.
- busy  out  1  state is not IDLE.
- done  out  1  one-cycle pulse after the final handshake.

Behaviour:
- Reset: all outputs 0, state IDLE, latched bounds 0. Reset applied mid-sequence discards it and produces no done pulse.
- States: IDLE, RUN, DONE.
- IDLE -> RUN on start:
  - Latch cfg_*. A value of 0 or greater than MAX_* is replaced by MAX_*.
  - Clear all indices.
  - The next cycle shows valid=1 with index (0,0,0). Latency from start to first valid is 1 cycle.
- RUN:
  - Handshake = valid && ready. Without a handshake, indices and flags hold.
  - On handshake, col_idx increments.
  - If last_col: col_idx wraps to 0 and row_idx increments.
  - If last_row: row_idx also wraps to 0 and tile_idx increments.
  - If last: go to DONE, valid=0, indices return to 0.
- DONE: done=1 for exactly one cycle, busy=1, then IDLE.
- start is accepted only in IDLE. start in RUN or DONE is ignored, and the latched bounds do not change.
- abort (any state except IDLE): next cycle IDLE, valid=0, indices 0, no done pulse.
- abort together with the final handshake: abort wins, no done.
- abort together with start in IDLE: start is ignored.
- last_col, last_row and last are combinational from registered indices and latched bounds. They are 0 whenever valid=0.
- Bounds of 1: the corresponding index stays 0 and its last flag is constantly asserted while valid.
- Total handshakes per sequence = cols*rows*tiles. Ordering is col fastest, tile slowest.

Optional Feature:
- Macro TILE_IDX_SERPENTINE_EN.
- Defined: on odd row_idx, columns are traversed cols-1 down to 0.
  - last_col asserts at col_idx == 0 on odd rows.
  - When entering an odd row, col_idx starts at cols-1.
  - The row_idx/tile_idx sequence is unchanged.
- Undefined: columns always ascend; no direction logic is synthesised.

Decomposition:
- Shared package tile_pkg holds:
  - the state enum (IDLE/RUN/DONE);
  - the clamp function (0 or >MAX -> MAX);
  - the width-derivation constants.
- One natural sub-module: wrap_cnt, a single-level counter with enable, clear, runtime bound, wrap output and direction input (direction used only under TILE_IDX_SERPENTINE_EN). It is instantiated three times and chained through its wrap outputs.

Test Plan:
- Basic sequence:
  - Stimulus: cfg 3x2x2, ready=1, start pulse.
  - Response: 12 valid cycles, first index (0,0,0) one cycle after start, last index (2,1,1) with last=1.
  - Then done=1 for exactly one cycle, then busy=0.
- Back-pressure:
  - Stimulus: cfg 4x1x1, ready toggles 1,0,0,1,...
  - Response: indices hold while ready=0; exactly 4 handshakes; done follows the 4th.
- Clamp:
  - Stimulus: cfg_cols=0, cfg_rows=40, cfg_tiles=1, with MAX defaults.
  - Response: 32*32 = 1024 handshakes; last_col asserts at col_idx 31.
- Abort and start during run:
  - Stimulus: cfg 8x8x1, start, then at handshake 10 pulse abort together with start.
  - Response: valid=0 and IDLE next cycle, no done. A later start with 2x2x1 gives exactly 4 handshakes.
- Reset mid-run:
  - Stimulus: rst asserted in RUN at index (5,3,0).
  - Response: next cycle all outputs 0, done never pulses; the following start begins at (0,0,0).
- Serpentine (with TILE_IDX_SERPENTINE_EN):
  - Stimulus: cfg 3x2x1.
  - Response: col sequence 0,1,2,2,1,0; last_col at col 2 (row 0) and col 0 (row 1).
